// File: rtl/farrow_pkg.sv
`default_nettype none
// ============================================================================
//  farrow_pkg
//  Shared types, half-precision constants and IEEE binary16 helpers.
//  Revision: 1.0
// ============================================================================
package farrow_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MUL_ISSUE = 3'd1,
        MUL_WAIT  = 3'd2,
        ADD_ISSUE = 3'd3,
        ADD_WAIT  = 3'd4,
        DONE      = 3'd5
    } horner_state_t;

    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_ONE  = 16'h3C00;
    localparam logic [15:0] FP16_QNAN = 16'h7E00;
    localparam int          MAX_ORDER = 7;

    // Leading-zero count of a 22-bit vector; returns 22 for an all-zero input.
    function automatic logic [4:0] fp_clz22(input logic [21:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd22;
        found = 1'b0;
        for (int i = 21; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(21 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // sig = {1, frac[9:0], guard, round, sticky} normalised, value 1.f * 2^(e_b-15).
    // Denormalises when e_b <= 0, then rounds to nearest-even; the final
    // increment carries naturally from fraction into exponent and up to Inf.
    function automatic logic [15:0] fp16_round_pack(input logic sgn, input int e_b,
                                                    input logic [13:0] sig);
        logic [27:0] wide;
        logic [13:0] s;
        logic [4:0]  ex;
        logic        inc;
        logic [14:0] mag;
        int          sh;
        if (e_b >= 31) begin
            return {sgn, 5'h1F, 10'h000};
        end
        if (e_b >= 1) begin
            s  = sig;
            ex = e_b[4:0];
        end else begin
            sh = 1 - e_b;
            if (sh > 15) begin
                sh = 15;
            end
            wide = {sig, 14'b0} >> sh;
            s    = {wide[27:15], (wide[14] | (|wide[13:0]))};
            ex   = 5'd0;
        end
        inc = s[2] & (s[1] | s[0] | s[3]);
        mag = {ex, s[12:3]} + 15'(inc);
        return {sgn, mag};
    endfunction

endpackage : farrow_pkg
`default_nettype wire

// File: rtl/add.sv
`default_nettype none
// ============================================================================
//  add
//  Binary16 adder, round-to-nearest-even, one-cycle registered result.
//  Revision: 1.0
// ============================================================================
module add
    import farrow_pkg::*;
#(
    parameter int BITS      = 16,
    parameter     PRECISION = "HALF"
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic            out_valid,
    output logic [BITS-1:0] c
);

    generate
        if (BITS != 16 || PRECISION != "HALF") begin : g_bad_precision
            $error("add: only BITS=16 / PRECISION=HALF is implemented");
        end
    endgenerate

    logic [15:0] w_big, w_sml, w_res;
    logic [4:0]  w_xb, w_xs, w_d, w_dcl, w_lz;
    logic [13:0] w_mb, w_ms, w_al;
    logic [27:0] w_wide;
    logic [14:0] w_sum, w_norm;
    logic        w_sub, w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    int          w_exp;

    always_comb begin
        w_a_nan = (&a[14:10]) & (|a[9:0]);
        w_b_nan = (&b[14:10]) & (|b[9:0]);
        w_a_inf = (&a[14:10]) & ~(|a[9:0]);
        w_b_inf = (&b[14:10]) & ~(|b[9:0]);
        // Larger magnitude first so the aligned difference is never negative.
        if (b[14:0] > a[14:0]) begin
            w_big = b;
            w_sml = a;
        end else begin
            w_big = a;
            w_sml = b;
        end
        w_xb   = (w_big[14:10] == 5'd0) ? 5'd1 : w_big[14:10];
        w_xs   = (w_sml[14:10] == 5'd0) ? 5'd1 : w_sml[14:10];
        w_d    = w_xb - w_xs;
        w_dcl  = (w_d > 5'd15) ? 5'd15 : w_d;
        w_mb   = {(|w_big[14:10]), w_big[9:0], 3'b000};
        w_ms   = {(|w_sml[14:10]), w_sml[9:0], 3'b000};
        w_wide = {w_ms, 14'b0} >> w_dcl;
        w_al   = {w_wide[27:15], (w_wide[14] | (|w_wide[13:0]))};
        w_sub  = w_big[15] ^ w_sml[15];
        w_sum  = w_sub ? ({1'b0, w_mb} - {1'b0, w_al}) : ({1'b0, w_mb} + {1'b0, w_al});
        w_lz   = fp_clz22({w_sum, 7'b0});
        w_norm = w_sum << w_lz;
        w_exp  = int'(w_xb) + 1 - int'(w_lz);

        if (w_a_nan) begin
            w_res = a;
        end else if (w_b_nan) begin
            w_res = b;
        end else if (w_a_inf && w_b_inf && (a[15] != b[15])) begin
            w_res = FP16_QNAN;
        end else if (w_a_inf) begin
            w_res = a;
        end else if (w_b_inf) begin
            w_res = b;
        end else if (w_sum == 15'd0) begin
            // Exact cancellation yields +0; equal-signed zeros keep their sign.
            w_res = {(w_sub ? 1'b0 : w_big[15]), 15'h0000};
        end else begin
            w_res = fp16_round_pack(w_big[15], w_exp, {w_norm[14:2], (|w_norm[1:0])});
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            c         <= FP16_ZERO;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                c <= w_res;
            end
        end
    end

endmodule : add
`default_nettype wire

// File: rtl/multiply.sv
`default_nettype none
// ============================================================================
//  multiply
//  Binary16 multiplier, round-to-nearest-even, one-cycle registered result.
//  Revision: 1.0
// ============================================================================
module multiply
    import farrow_pkg::*;
#(
    parameter int BITS      = 16,
    parameter     PRECISION = "HALF"
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic            out_valid,
    output logic [BITS-1:0] c
);

    generate
        if (BITS != 16 || PRECISION != "HALF") begin : g_bad_precision
            $error("multiply: only BITS=16 / PRECISION=HALF is implemented");
        end
    endgenerate

    logic [4:0]  w_ea, w_eb, w_xa, w_xb, w_lz;
    logic [10:0] w_sa, w_sb;
    logic [21:0] w_prod, w_norm;
    logic        w_sgn, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    int          w_exp;
    logic [15:0] w_res;

    always_comb begin
        w_ea     = a[14:10];
        w_eb     = b[14:10];
        w_sgn    = a[15] ^ b[15];
        w_a_nan  = (&w_ea) & (|a[9:0]);
        w_b_nan  = (&w_eb) & (|b[9:0]);
        w_a_inf  = (&w_ea) & ~(|a[9:0]);
        w_b_inf  = (&w_eb) & ~(|b[9:0]);
        w_a_zero = ~(|a[14:0]);
        w_b_zero = ~(|b[14:0]);
        // Subnormals carry no hidden bit but share the exponent of 1.
        w_xa     = (w_ea == 5'd0) ? 5'd1 : w_ea;
        w_xb     = (w_eb == 5'd0) ? 5'd1 : w_eb;
        w_sa     = {(|w_ea), a[9:0]};
        w_sb     = {(|w_eb), b[9:0]};
        w_prod   = w_sa * w_sb;
        w_lz     = fp_clz22(w_prod);
        w_norm   = w_prod << w_lz;
        w_exp    = int'(w_xa) + int'(w_xb) - 14 - int'(w_lz);

        if (w_a_nan) begin
            w_res = a;
        end else if (w_b_nan) begin
            w_res = b;
        end else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            w_res = FP16_QNAN;
        end else if (w_a_inf || w_b_inf) begin
            w_res = {w_sgn, 5'h1F, 10'h000};
        end else if (w_a_zero || w_b_zero) begin
            w_res = {w_sgn, 15'h0000};
        end else begin
            w_res = fp16_round_pack(w_sgn, w_exp, {w_norm[21:9], (|w_norm[8:0])});
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            c         <= FP16_ZERO;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                c <= w_res;
            end
        end
    end

endmodule : multiply
`default_nettype wire

// File: rtl/farrow_horner.sv
`default_nettype none
// ============================================================================
//  farrow_horner
//  Iterative Horner combiner y = c0 + mu*(c1 + mu*(... + mu*c_ORDER)).
//  Revision: 1.0
// ============================================================================
module farrow_horner
    import farrow_pkg::*;
#(
    parameter int BITS      = 16,
    parameter     PRECISION = "HALF",
    parameter int ORDER     = 3
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [(ORDER+1)*BITS-1:0] branch_in,
    input  logic [BITS-1:0]           mu,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BITS-1:0]           y
);

    generate
        if (ORDER < 1 || ORDER > MAX_ORDER) begin : g_bad_order
            $error("farrow_horner: ORDER must lie in 1..7");
        end
    endgenerate

    localparam int c_K_W = 3;

    horner_state_t             r_state, w_next;
    logic [(ORDER+1)*BITS-1:0] r_coef;
    logic [BITS-1:0]           r_mu, r_acc, r_prod, r_y;
    logic [c_K_W-1:0]          r_k;
    logic                      r_out_valid;
    logic                      w_mul_in_valid, w_add_in_valid;
    logic                      w_mul_out_valid, w_add_out_valid;
    logic [BITS-1:0]           w_mul_c, w_add_c, w_ck;

    assign w_ck      = r_coef[int'(r_k)*BITS +: BITS];
    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign y         = r_y;

    always_comb begin
        w_next         = r_state;
        w_mul_in_valid = 1'b0;
        w_add_in_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_next = MUL_ISSUE;
                end
            end
            MUL_ISSUE: begin
                w_mul_in_valid = 1'b1;
                w_next         = MUL_WAIT;
            end
            MUL_WAIT: begin
                if (w_mul_out_valid) begin
                    w_next = ADD_ISSUE;
                end
            end
            ADD_ISSUE: begin
                w_add_in_valid = 1'b1;
                w_next         = ADD_WAIT;
            end
            ADD_WAIT: begin
                if (w_add_out_valid) begin
                    w_next = (r_k == '0) ? DONE : MUL_ISSUE;
                end
            end
            DONE: begin
                if (r_out_valid && out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_coef      <= '0;
            r_mu        <= '0;
            r_acc       <= '0;
            r_prod      <= '0;
            r_k         <= '0;
            r_y         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_coef <= branch_in;
                        r_mu   <= mu;
                        r_acc  <= branch_in[ORDER*BITS +: BITS];
                        r_k    <= c_K_W'(ORDER - 1);
                    end
                end
                MUL_WAIT: begin
                    if (w_mul_out_valid) begin
                        r_prod <= w_mul_c;
                    end
                end
                ADD_WAIT: begin
                    if (w_add_out_valid) begin
                        r_acc <= w_add_c;
                        if (r_k != '0) begin
                            r_k <= r_k - c_K_W'(1);
                        end
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the result; it then holds until taken.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_y         <= r_acc;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    multiply #(
        .BITS      (BITS),
        .PRECISION (PRECISION)
    ) u_multiply (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (w_mul_in_valid),
        .a         (r_acc),
        .b         (r_mu),
        .out_valid (w_mul_out_valid),
        .c         (w_mul_c)
    );

    add #(
        .BITS      (BITS),
        .PRECISION (PRECISION)
    ) u_add (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (w_add_in_valid),
        .a         (r_prod),
        .b         (w_ck),
        .out_valid (w_add_out_valid),
        .c         (w_add_c)
    );

endmodule : farrow_horner
`default_nettype wire

// File: tb/tb_farrow_horner.sv
`default_nettype none
// ============================================================================
//  tb_farrow_horner
//  Directed and random checks of the Horner combiner against a real-valued model.
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_farrow_horner;
    import farrow_pkg::*;

    localparam int ORDER  = 3;
    localparam int LM     = 1;
    localparam int LA     = 1;
    localparam int STEP   = LM + LA + 2;
    localparam int LAT    = ORDER * STEP + 1;
    localparam int PERIOD = ORDER * STEP + 3;

    logic        clk       = 1'b0;
    logic        rstn      = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic [63:0] branch_in = '0;
    logic [15:0] mu        = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] y;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_acc    = 0;

    farrow_horner #(
        .BITS      (16),
        .PRECISION ("HALF"),
        .ORDER     (ORDER)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .branch_in (branch_in),
        .mu        (mu),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic real pow2(input int e);
        real r;
        r = 1.0;
        if (e >= 0) repeat (e) r = r * 2.0;
        else        repeat (-e) r = r / 2.0;
        return r;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        int  e;
        real m;
        e = int'(h[14:10]);
        if (e == 0) m = real'(int'(h[9:0])) * pow2(-24);
        else        m = real'(1024 + int'(h[9:0])) * pow2(e - 25);
        return h[15] ? -m : m;
    endfunction

    // Round a real to the nearest binary16 value, ties to even.
    function automatic logic [15:0] r2h(input real x);
        logic s;
        real  a, q, fl;
        int   e, m;
        s = (x < 0.0);
        a = s ? -x : x;
        if (a == 0.0) return 16'h0000;
        if (a >= 65520.0) return {s, 15'h7C00};
        if (a < pow2(-14)) begin
            q  = a * pow2(24);
            fl = $floor(q);
            m  = int'(fl);
            if ((q - fl > 0.5) || ((q - fl == 0.5) && (m % 2 == 1))) m++;
            return {s, 15'(m)};
        end
        e = -14;
        while (a >= pow2(e + 1)) e++;
        q  = a * pow2(10 - e);
        fl = $floor(q);
        m  = int'(fl);
        if ((q - fl > 0.5) || ((q - fl == 0.5) && (m % 2 == 1))) m++;
        if (m == 2048) begin
            m = 1024;
            e++;
        end
        if (e > 15) return {s, 15'h7C00};
        return {s, 5'(e + 15), 10'(m - 1024)};
    endfunction

    // Horner evaluation with every product and sum rounded to half precision.
    function automatic logic [15:0] model(input logic [63:0] br, input logic [15:0] m);
        logic [15:0] acc;
        acc = br[ORDER*16 +: 16];
        for (int k = ORDER - 1; k >= 0; k--) begin
            acc = r2h(h2r(acc) * h2r(m));
            acc = r2h(h2r(acc) + h2r(br[k*16 +: 16]));
        end
        return acc;
    endfunction

    function automatic logic [15:0] rnd_coef();
        return {1'($urandom_range(0, 1)), 5'($urandom_range(10, 19)), 10'($urandom)};
    endfunction

    function automatic logic [15:0] rnd_mu();
        return {1'b0, 5'($urandom_range(11, 14)), 10'($urandom)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered and left on a falling edge; leaves in_valid high when keep is set.
    task automatic send(input logic [63:0] br, input logic [15:0] m, input logic keep);
        int n;
        n         = 0;
        branch_in = br;
        mu        = m;
        in_valid  = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n < 200), 32'd1);
        @(posedge clk);
        #1 t_acc = cyc;
        @(negedge clk);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        int n;
        n = 0;
        while (!out_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        lat = n;
    endtask

    initial begin
        int          lat;
        int          t_prev;
        logic [63:0] br;
        logic [15:0] m;
        logic [15:0] exp_q[$];
        logic [15:0] exp_y;

        rstn      = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_y", 32'(y), 32'(FP16_ZERO));
        rstn = 1'b1;
        @(negedge clk);

        send({4{FP16_ONE}}, 16'h3800, 1'b0);
        wait_out(lat);
        chk("mu_half_latency", 32'(lat), 32'(LAT));
        chk("mu_half_y", 32'(y), 32'h3F80);
        @(negedge clk);
        chk("mu_half_consumed", 32'(out_valid), 32'd0);

        send({4{FP16_ONE}}, 16'h4000, 1'b0);
        wait_out(lat);
        chk("mu_two_y", 32'(y), 32'h4B80);
        @(negedge clk);

        send({16'h5640, 16'hC100, 16'h3555, 16'h4200}, FP16_ZERO, 1'b0);
        wait_out(lat);
        chk("mu_zero_y", 32'(y), 32'h4200);
        @(negedge clk);

        out_ready = 1'b0;
        send({4{FP16_ONE}}, 16'h3800, 1'b0);
        wait_out(lat);
        for (int i = 0; i < 10; i++) begin
            chk("bp_y_stable", 32'(y), 32'h3F80);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);

        send({4{FP16_ONE}}, 16'h3800, 1'b0);
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_y", 32'(y), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_no_output", 32'(out_valid), 32'd0);
        send({16'h4000, 16'h0000, 16'h0000, 16'h0000}, FP16_ONE, 1'b0);
        wait_out(lat);
        chk("midrst_fresh_latency", 32'(lat), 32'(LAT));
        chk("midrst_fresh_y", 32'(y), 32'h4000);
        @(negedge clk);

        t_prev = 0;
        for (int i = 0; i < 25; i++) begin
            br = {rnd_coef(), rnd_coef(), rnd_coef(), rnd_coef()};
            m  = rnd_mu();
            send(br, m, 1'b1);
            exp_q.push_back(model(br, m));
            if (i > 0) chk("b2b_period", 32'(t_acc - t_prev), 32'(PERIOD));
            t_prev = t_acc;
            wait_out(lat);
            chk("b2b_latency", 32'(lat), 32'(LAT));
            exp_y = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
            chk("b2b_y", 32'(y), 32'(exp_y));
            @(negedge clk);
            chk("b2b_no_duplicate", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        chk("b2b_queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_farrow_horner
`default_nettype wire
